afe_pulse_receiver: RTL and testbench

AFE_PULSE_RECEIVER -- requirements
Module: afe_pulse_receiver

---
 rtl/afe_pulse_receiver.sv | 181 ++++++++++++++++++
 tb/tb_afe_pulse_receiver.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/afe_pulse_receiver.sv
// Measures the width of active pulses on a 6-sample-per-cycle ISERDES stream,
// reporting width, leading-edge bit position and a clip flag per pulse.
module afe_pulse_receiver (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  in_word,
  input  logic        y0,
  input  logic        enable,
  input  logic [15:0] max_width,
  output logic [15:0] width,
  output logic [2:0]  lead_pos,
  output logic        valid,
  output logic        overflow,
  output logic        busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEAS     = 2'd1;
  localparam logic [1:0] S_WAIT_LOW = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [15:0] limit_q, limit_d;
  logic [2:0]  lead_q, lead_d;
  logic        prev_q, prev_d;
  logic [15:0] width_q, width_d;
  logic [2:0]  lead_pos_q, lead_pos_d;
  logic        valid_q, valid_d;
  logic        overflow_q, overflow_d;

  logic [5:0]  w;
  logic [5:0]  edges;
  logic [5:0]  zero_hi;
  logic [2:0]  edge_idx;
  logic [2:0]  zero_hi_idx;
  logic [2:0]  zero_idx;
  logic [15:0] limit_new;
  logic [16:0] start_cnt;
  logic [16:0] meas_sum;

  // Result staging: the FSM picks a raw width, the limit it is judged
  // against and the lead position; clipping is applied in one place.
  logic        fire;
  logic [16:0] res_raw;
  logic [15:0] res_lim;
  logic [2:0]  res_lead;

  function automatic logic [2:0] lowest_set(input logic [5:0] v);
    lowest_set = 3'd0;
    for (int k = 5; k >= 0; k--) begin
      if (v[k]) lowest_set = k[2:0];
    end
  endfunction

  assign w           = y0 ? ~in_word : in_word;
  assign edges       = w & ~{w[4:0], prev_q};
  assign edge_idx    = lowest_set(edges);
  assign zero_hi     = ~w & (6'h3E << edge_idx);
  assign zero_hi_idx = lowest_set(zero_hi);
  assign zero_idx    = lowest_set(~w);
  assign limit_new   = (max_width == 16'd0) ? 16'hFFFF : max_width;
  assign start_cnt   = 17'd6 - {14'd0, edge_idx};
  assign meas_sum    = cnt_q + 17'd6;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    limit_d    = limit_q;
    lead_d     = lead_q;
    prev_d     = w[5];
    fire       = 1'b0;
    res_raw    = 17'd0;
    res_lim    = limit_q;
    res_lead   = lead_q;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = 17'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|edges) begin
            limit_d  = limit_new;
            lead_d   = edge_idx;
            res_lim  = limit_new;
            res_lead = edge_idx;
            if (|zero_hi) begin
              fire    = 1'b1;
              res_raw = {14'd0, zero_hi_idx} - {14'd0, edge_idx};
            end else if (start_cnt > {1'b0, limit_new}) begin
              fire    = 1'b1;
              res_raw = start_cnt;
              cnt_d   = 17'd0;
              state_d = S_WAIT_LOW;
            end else begin
              cnt_d   = start_cnt;
              state_d = S_MEAS;
            end
          end
        end
        S_MEAS: begin
          if (w == 6'h3F) begin
            if (meas_sum > {1'b0, limit_q}) begin
              fire    = 1'b1;
              res_raw = meas_sum;
              cnt_d   = 17'd0;
              state_d = S_WAIT_LOW;
            end else begin
              cnt_d = meas_sum;
            end
          end else begin
            fire    = 1'b1;
            res_raw = cnt_q + {14'd0, zero_idx};
            cnt_d   = 17'd0;
            state_d = S_IDLE;
          end
        end
        S_WAIT_LOW: begin
          if (w != 6'h3F) begin
            state_d = S_IDLE;
            cnt_d   = 17'd0;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 17'd0;
        end
      endcase
    end

    valid_d    = fire;
    width_d    = width_q;
    lead_pos_d = lead_pos_q;
    overflow_d = overflow_q;
    if (fire) begin
      lead_pos_d = res_lead;
      if (res_raw > {1'b0, res_lim}) begin
        width_d    = res_lim;
        overflow_d = 1'b1;
      end else begin
        width_d    = res_raw[15:0];
        overflow_d = 1'b0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 17'd0;
      limit_q    <= 16'hFFFF;
      lead_q     <= 3'd0;
      prev_q     <= 1'b1;
      width_q    <= 16'd0;
      lead_pos_q <= 3'd0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      limit_q    <= limit_d;
      lead_q     <= lead_d;
      prev_q     <= prev_d;
      width_q    <= width_d;
      lead_pos_q <= lead_pos_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign width    = width_q;
  assign lead_pos = lead_pos_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = (state_q == S_MEAS) || (state_q == S_WAIT_LOW);

endmodule

// File: tb/tb_afe_pulse_receiver.sv
// Scoreboard bench for afe_pulse_receiver: each terminating word pushes its
// expected result and the cycle it must appear; a monitor pops on valid.
module tb_afe_pulse_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  in_word;
  logic        y0;
  logic        enable;
  logic [15:0] max_width;
  logic [15:0] width;
  logic [2:0]  lead_pos;
  logic        valid;
  logic        overflow;
  logic        busy;

  afe_pulse_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .in_word   (in_word),
    .y0        (y0),
    .enable    (enable),
    .max_width (max_width),
    .width     (width),
    .lead_pos  (lead_pos),
    .valid     (valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] w;
    logic [2:0]  l;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_cycle", cyc, e.due);
        check("width", {16'd0, width}, {16'd0, e.w});
        check("lead_pos", {29'd0, lead_pos}, {29'd0, e.l});
        check("overflow", {31'd0, overflow}, {31'd0, e.o});
      end
    end
  end

  // Drive one word at the falling edge, optionally register its expected
  // result, then check busy just after the edge that samples it.
  task automatic drive(input logic [5:0] word, input logic exp_busy,
                       input logic has_res = 1'b0, input logic [15:0] ew = 16'd0,
                       input logic [2:0] el = 3'd0, input logic eo = 1'b0);
    exp_t e;
    @(negedge clk);
    in_word = word;
    if (has_res) begin
      e.due = cyc + 1;
      e.w   = ew;
      e.l   = el;
      e.o   = eo;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 check("busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic check_reset_state();
    check("rst_width", {16'd0, width}, 32'd0);
    check("rst_lead", {29'd0, lead_pos}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_word = 6'h00; y0 = 1'b0; enable = 1'b1; max_width = 16'd0;
    repeat (2) @(posedge clk);
    #1 check_reset_state();
    @(negedge clk) rst = 1'b0;

    // Multi-word pulse: 4 + 6 + 2 samples starting at bit 2.
    drive(6'h00, 1'b0);
    drive(6'h3C, 1'b1);
    drive(6'h3F, 1'b1);
    drive(6'h03, 1'b0, 1'b1, 16'd12, 3'd2, 1'b0);
    drive(6'h00, 1'b0);

    // Pulse contained in one word never raises busy.
    drive(6'h00, 1'b0);
    drive(6'h0E, 1'b0, 1'b1, 16'd3, 3'd1, 1'b0);
    drive(6'h00, 1'b0);

    // Inverted line gives the identical result.
    y0 = 1'b1;
    drive(6'h3F, 1'b0);
    drive(6'h31, 1'b0, 1'b1, 16'd3, 3'd1, 1'b0);
    drive(6'h3F, 1'b0);
    y0 = 1'b0;

    // Line active through reset release is not a pulse.
    @(negedge clk);
    rst = 1'b1; in_word = 6'h3F;
    repeat (2) @(posedge clk);
    #1 check_reset_state();
    @(negedge clk) rst = 1'b0;
    drive(6'h3F, 1'b0);
    drive(6'h3F, 1'b0);
    drive(6'h00, 1'b0);
    drive(6'h01, 1'b0, 1'b1, 16'd1, 3'd0, 1'b0);
    drive(6'h00, 1'b0);

    // Clip while active: report at once, then wait for the line to drop.
    max_width = 16'd10;
    drive(6'h00, 1'b0);
    drive(6'h3F, 1'b1);
    drive(6'h3F, 1'b1, 1'b1, 16'd10, 3'd0, 1'b1);
    drive(6'h3F, 1'b1);
    drive(6'h00, 1'b0);

    // Limit boundaries on in-word pulses and an immediate start overflow.
    max_width = 16'd3;
    drive(6'h0E, 1'b0, 1'b1, 16'd3, 3'd1, 1'b0);
    max_width = 16'd2;
    drive(6'h00, 1'b0);
    drive(6'h0E, 1'b0, 1'b1, 16'd2, 3'd1, 1'b1);
    drive(6'h00, 1'b0);
    drive(6'h38, 1'b1, 1'b1, 16'd2, 3'd3, 1'b1);
    drive(6'h00, 1'b0);
    max_width = 16'd0;

    // Reset mid-measurement aborts the pulse.
    drive(6'h00, 1'b0);
    drive(6'h3F, 1'b1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("busy_after_rst", {31'd0, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    drive(6'h3F, 1'b0);
    drive(6'h00, 1'b0);
    drive(6'h07, 1'b0, 1'b1, 16'd3, 3'd0, 1'b0);

    // Disable mid-measurement aborts the pulse; next pulse measures cleanly.
    drive(6'h00, 1'b0);
    drive(6'h3F, 1'b1);
    enable = 1'b0;
    drive(6'h3F, 1'b0);
    enable = 1'b1;
    drive(6'h3F, 1'b0);
    drive(6'h00, 1'b0);
    drive(6'h38, 1'b1);
    drive(6'h3F, 1'b1);
    drive(6'h00, 1'b0, 1'b1, 16'd9, 3'd3, 1'b0);

    repeat (4) @(posedge clk);
    #1 check("pending_results", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
